// File: rtl/eth_rx_xgmii_decoder.sv
// XGMII 64-bit RX decoder: start/preamble/SFD detection, one-word hold stage,
// CRC-32 and length checking, push-only frame output with good/bad counters.
module eth_rx_xgmii_decoder #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [63:0]      xgmii_rxd,
    input  logic [7:0]       xgmii_rxc,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic [7:0]       out_keep,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic             out_crc_err,
    output logic [15:0]      out_len,
    output logic [CNT_W-1:0] stat_good,
    output logic [CNT_W-1:0] stat_bad
);

    localparam logic [63:0] START_WORD  = 64'hD5555555555555FB;
    localparam logic [7:0]  START_CTRL  = 8'h01;
    localparam logic [7:0]  CH_TERM     = 8'hFD;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    state_t      state;
    logic [63:0] hold_data;
    logic [7:0]  hold_keep;
    logic        hold_valid;
    logic        hold_sop;
    logic        hold_eop;
    logic        first_word;
    logic [31:0] crc_reg;
    logic [15:0] byte_cnt;

    logic        ctrl_found;
    logic [2:0]  ctrl_lane;
    logic [7:0]  ctrl_char;
    logic        is_term;
    logic [7:0]  term_mask;
    logic [63:0] term_data;
    logic        start_ok;
    logic        emit;
    logic        emit_eop;
    logic        ctrl_err;
    logic        crc_bad;
    logic        len_err;

    function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                               input logic [63:0] data,
                                               input logic [7:0]  keep);
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (keep[i]) begin
                c = c ^ {24'd0, data[8*i +: 8]};
                for (int unsigned b = 0; b < 8; b++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Lowest-numbered control lane decides how the word is interpreted.
    always_comb begin
        ctrl_lane = 3'd0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (xgmii_rxc[i-1]) begin
                ctrl_lane = 3'(i - 1);
            end
        end
        ctrl_found = |xgmii_rxc;
        ctrl_char  = xgmii_rxd[{ctrl_lane, 3'b000} +: 8];
        is_term    = ctrl_found && (ctrl_char == CH_TERM);
        term_mask  = (8'd1 << ctrl_lane) - 8'd1;
        term_data  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (term_mask[i]) begin
                term_data[8*i +: 8] = xgmii_rxd[8*i +: 8];
            end
        end
        start_ok = (xgmii_rxc == START_CTRL) && (xgmii_rxd == START_WORD);
    end

    // A held word is released either because a partial final word sits in
    // hold already, or because the next DATA-state word decides its fate.
    always_comb begin
        emit     = 1'b0;
        emit_eop = 1'b0;
        ctrl_err = 1'b0;
        if (hold_valid && hold_eop) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
        end else if (state == S_DATA && hold_valid) begin
            emit = 1'b1;
            if (ctrl_found && !(is_term && ctrl_lane != 3'd0)) begin
                emit_eop = 1'b1;
                ctrl_err = !is_term;
            end
        end
        crc_bad = (crc_reg != CRC_RESIDUE);
        len_err = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            hold_data   <= '0;
            hold_keep   <= '0;
            hold_valid  <= 1'b0;
            hold_sop    <= 1'b0;
            hold_eop    <= 1'b0;
            first_word  <= 1'b0;
            crc_reg     <= '1;
            byte_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_keep    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_err     <= 1'b0;
            out_crc_err <= 1'b0;
            out_len     <= '0;
        end else begin
            out_valid   <= emit;
            out_data    <= emit ? hold_data : '0;
            out_keep    <= emit ? hold_keep : '0;
            out_sop     <= emit && hold_sop;
            out_eop     <= emit_eop;
            out_err     <= emit_eop && (crc_bad || len_err || ctrl_err);
            out_crc_err <= emit_eop && crc_bad;
            out_len     <= emit_eop ? byte_cnt : '0;

            if (emit) begin
                hold_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state      <= S_DATA;
                        crc_reg    <= '1;
                        byte_cnt   <= '0;
                        first_word <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (!ctrl_found) begin
                        hold_data  <= xgmii_rxd;
                        hold_keep  <= 8'hFF;
                        hold_valid <= 1'b1;
                        hold_sop   <= first_word;
                        hold_eop   <= 1'b0;
                        first_word <= 1'b0;
                        crc_reg    <= crc_update(crc_reg, xgmii_rxd, 8'hFF);
                        byte_cnt   <= sat_add(byte_cnt, 4'd8);
                    end else if (is_term && ctrl_lane != 3'd0) begin
                        hold_data  <= term_data;
                        hold_keep  <= term_mask;
                        hold_valid <= 1'b1;
                        hold_sop   <= first_word;
                        hold_eop   <= 1'b1;
                        first_word <= 1'b0;
                        crc_reg    <= crc_update(crc_reg, xgmii_rxd, term_mask);
                        byte_cnt   <= sat_add(byte_cnt, {1'b0, ctrl_lane});
                        state      <= S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_good <= '0;
            stat_bad  <= '0;
        end else if (out_valid && out_eop) begin
            if (out_err) begin
                stat_bad <= stat_bad + CNT_W'(1);
            end else begin
                stat_good <= stat_good + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_xgmii_decoder.sv
// Scoreboard bench for eth_rx_xgmii_decoder: frames are generated with a real
// FCS, expected output words are queued at drive time and popped on output.
module tb_eth_rx_xgmii_decoder;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [63:0] START_D = 64'hD5555555555555FB;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic [7:0]  keep;
        bit          sop;
        bit          eop;
        bit          err;
        bit          crc_err;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] xgmii_rxd = IDLE_D;
    logic [7:0]  xgmii_rxc = 8'hFF;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic        out_crc_err;
    logic [15:0] out_len;
    logic [31:0] stat_good;
    logic [31:0] stat_bad;

    int   n_vec = 0;
    int   n_miscompare = 0;
    int   cyc = 0;
    int   exp_good = 0;
    int   exp_bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] fb[$];

    eth_rx_xgmii_decoder #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .xgmii_rxd  (xgmii_rxd),
        .xgmii_rxc  (xgmii_rxc),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_err    (out_err),
        .out_crc_err(out_crc_err),
        .out_len    (out_len),
        .stat_good  (stat_good),
        .stat_bad   (stat_bad)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] keep);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (keep[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        fb.delete();
        if (n == 0) return;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'($urandom);
            fb.push_back(b);
            crc = crc_byte(crc, b);
        end
        fcs = ~crc;
        for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
    endtask

    task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
        @(posedge clk);
        #1;
        xgmii_rxd = d;
        xgmii_rxc = c;
    endtask

    task automatic close_frame(input exp_t p, input int cnt, input logic [31:0] crc, input bit ctrl);
        exp_t e;
        e = p;
        e.eop = 1;
        e.len = 16'(cnt);
        e.crc_err = (crc != RESIDUE);
        e.err = e.crc_err || (cnt < 64) || (cnt > 1518) || ctrl;
        sb.push_back(e);
        if (e.err) exp_bad++;
        else exp_good++;
    endtask

    // err_word/abort_word are 1-based data-word indices; 0 disables them.
    task automatic drive_frame(input int err_word, input int abort_word);
        int          n;
        int          nfull;
        int          rem;
        int          cnt;
        bit          have;
        bit          first;
        logic [31:0] crc;
        logic [63:0] d;
        logic [7:0]  c;
        exp_t        pend;
        n = fb.size();
        nfull = n / 8;
        rem = n % 8;
        cnt = 0;
        have = 0;
        first = 1;
        crc = 32'hFFFFFFFF;
        drive_word(START_D, 8'h01);
        for (int w = 0; w < nfull; w++) begin
            if (err_word == w + 1) begin
                d = IDLE_D;
                for (int k = 0; k < 3; k++) d[8*k +: 8] = fb[8*w + k];
                d[31:24] = 8'hFE;
                drive_word(d, 8'hF8);
                if (have) close_frame(pend, cnt, crc, 1);
                return;
            end
            for (int k = 0; k < 8; k++) d[8*k +: 8] = fb[8*w + k];
            drive_word(d, 8'h00);
            if (have) sb.push_back(pend);
            pend.due = cyc + 2;
            pend.data = d;
            pend.keep = 8'hFF;
            pend.sop = first;
            pend.eop = 0;
            pend.err = 0;
            pend.crc_err = 0;
            pend.len = '0;
            first = 0;
            have = 1;
            for (int k = 0; k < 8; k++) crc = crc_byte(crc, fb[8*w + k]);
            cnt += 8;
            if (abort_word == w + 1) begin
                #1;
                reset_n = 1'b0;
                sb.delete();
                exp_good = 0;
                exp_bad = 0;
                return;
            end
        end
        d = IDLE_D;
        c = 8'hFF;
        for (int k = 0; k < rem; k++) begin
            d[8*k +: 8] = fb[8*nfull + k];
            c[k] = 1'b0;
            crc = crc_byte(crc, fb[8*nfull + k]);
        end
        d[8*rem +: 8] = 8'hFD;
        drive_word(d, c);
        if (rem == 0) begin
            if (have) close_frame(pend, cnt, crc, 0);
        end else begin
            if (have) sb.push_back(pend);
            pend.due = cyc + 2;
            pend.data = d;
            pend.keep = ~c;
            pend.sop = first;
            cnt += rem;
            close_frame(pend, cnt, crc, 0);
        end
    endtask

    task automatic settle();
        int t;
        drive_word(IDLE_D, 8'hFF);
        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            check_eq("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("stat_good", stat_good, 64'(exp_good));
        check_eq("stat_bad", stat_bad, 64'(exp_bad));
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                check_eq("out_valid", out_valid, 1);
                if (out_valid) begin
                    check_eq("out_data", out_data & lane_mask(mon_e.keep), mon_e.data & lane_mask(mon_e.keep));
                    check_eq("out_keep", out_keep, mon_e.keep);
                    check_eq("out_sop", out_sop, mon_e.sop);
                    check_eq("out_eop", out_eop, mon_e.eop);
                    if (mon_e.eop) begin
                        check_eq("out_len", out_len, mon_e.len);
                        check_eq("out_crc_err", out_crc_err, mon_e.crc_err);
                        check_eq("out_err", out_err, mon_e.err);
                    end
                end
            end else if (out_valid) begin
                check_eq("spurious_valid", out_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_eop", out_eop, 0);
        check_eq("rst_out_len", out_len, 0);
        check_eq("rst_stat_good", stat_good, 0);
        check_eq("rst_stat_bad", stat_bad, 0);
        reset_n = 1'b1;

        build_frame(64);
        drive_frame(0, 0);
        settle();

        build_frame(65);
        drive_frame(0, 0);
        settle();

        build_frame(64);
        fb[20] = fb[20] ^ 8'h01;
        drive_frame(0, 0);
        settle();

        build_frame(64);
        drive_frame(4, 0);
        settle();
        build_frame(70);
        drive_frame(0, 0);
        settle();

        drive_word(64'hD4555555555555FB, 8'h01);
        for (int w = 0; w < 8; w++) drive_word({$urandom, $urandom}, 8'h00);
        drive_word(64'h07070707070707FD, 8'hFF);
        settle();

        build_frame(60);
        drive_frame(0, 0);
        settle();

        build_frame(0);
        drive_frame(0, 0);
        settle();

        build_frame(1518);
        drive_frame(0, 0);
        settle();
        build_frame(1519);
        drive_frame(0, 0);
        settle();

        build_frame(64);
        drive_frame(0, 5);
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out_data", out_data, 0);
        check_eq("arst_stat_good", stat_good, 0);
        check_eq("arst_stat_bad", stat_bad, 0);
        drive_word(IDLE_D, 8'hFF);
        drive_word(IDLE_D, 8'hFF);
        reset_n = 1'b1;

        build_frame(64);
        drive_frame(0, 0);
        build_frame(64);
        drive_frame(0, 0);
        settle();
        check_eq("b2b_good_total", stat_good, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
